// File: rtl/config_mem_read_arbiter_if.sv
// Bus bundle for config_mem_read_arbiter.
// Groups the requester side (valid/addr/ready, one-hot response valid and
// shared response data), the config-mem read port (req/addr/gnt,
// rvalid/rdata) and the status flags (busy, err).
//   slave  : the arbiter's view (drives ready, responses, mem request, status)
//   master : the environment's view (requesters plus memory model)
interface config_mem_read_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_data_o;
  logic                      mem_req_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic                      mem_gnt_i;
  logic                      mem_rvalid_i;
  logic [DATA_W-1:0]         mem_rdata_i;
  logic                      busy_o;
  logic                      err_o;

  modport slave (
    input  req_valid_i, req_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, mem_req_o, mem_addr_o,
           busy_o, err_o
  );

  modport master (
    output req_valid_i, req_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, mem_req_o, mem_addr_o,
           busy_o, err_o
  );
endinterface

// File: rtl/config_mem_read_arbiter.sv
// Round-robin arbiter sharing the single read port of the model config memory
// between several schedulers. Accepted reads are tracked in an in-order ID
// FIFO so every returned word is routed, one cycle after mem_rvalid, to the
// requester that issued it.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : config_mem_read_arbiter_if.slave (requesters, mem port, status)
module config_mem_read_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  config_mem_read_arbiter_if.slave  bus
);

  localparam int REQ_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [REQ_W-1:0] LAST_REQ = REQ_W'(NUM_REQ - 1);

  logic [REQ_W-1:0]  rr_ptr;
  logic [REQ_W-1:0]  gnt_idx;
  logic [REQ_W-1:0]  cand;
  logic              found;
  logic [REQ_W-1:0]  id_fifo [MAX_OUTSTANDING];
  logic [REQ_W-1:0]  head_id;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              mem_req;
  logic              accept;
  logic              pop;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0]  rsp_data;
  logic               err;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    gnt_idx = rr_ptr;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = REQ_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && bus.req_valid_i[cand]) begin
        gnt_idx = cand;
        found   = 1'b1;
      end
    end
  end

  // Eligibility uses only the registered count: a pop in the same cycle
  // does not reopen a full FIFO until the following cycle.
  assign mem_req = (|bus.req_valid_i) && (count < CNT_MAX);
  assign accept  = mem_req && bus.mem_gnt_i;
  assign pop     = bus.mem_rvalid_i && (count != '0);
  assign head_id = id_fifo[rd_ptr];

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = mem_req ? bus.req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W] : '0;
  assign bus.req_ready_o = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign bus.busy_o      = (count != '0);
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = rsp_data;
  assign bus.err_o       = err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rsp_valid <= '0;
      if (pop) begin
        rsp_valid <= NUM_REQ'(1) << head_id;
        rsp_data  <= bus.mem_rdata_i;
      end
      // A response with nothing outstanding (e.g. left over from before a
      // reset) is dropped and flagged until the next reset.
      if (bus.mem_rvalid_i && (count == '0)) begin
        err <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      id_fifo[wr_ptr] <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_config_mem_read_arbiter.sv
module tb_config_mem_read_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic clk_i;
  logic rst_ni;
  int   cyc;
  int   n_tests;
  int   n_fail;

  config_mem_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  config_mem_read_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    logic [2:0]  rv;
    logic        gnt;
    logic        rval;
    logic [31:0] rdata;
    logic        exp_mreq;
    logic [2:0]  exp_rdy;
    logic [31:0] exp_addr;
    logic        exp_busy;
    logic [2:0]  exp_rsp;
  } vec_t;

  typedef struct {
    int          due;
    logic [2:0]  oh;
    logic [31:0] data;
  } rsp_t;

  vec_t vecs[$];
  rsp_t exp_q[$];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] rv, input logic gnt, input logic rval,
                     input logic [31:0] rdata, input logic mreq, input logic [2:0] rdy,
                     input logic [31:0] addr, input logic busy, input logic [2:0] rsp);
    vec_t v;
    v = '{rv, gnt, rval, rdata, mreq, rdy, addr, busy, rsp};
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: each expected response is due exactly one cycle after its
  // mem_rvalid; any other rsp_valid pulse is unexpected.
  always @(negedge clk_i) begin
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      chk($sformatf("rsp_valid@%0d", cyc), 32'(bus.rsp_valid_o), 32'(exp_q[0].oh));
      chk($sformatf("rsp_data@%0d", cyc), 32'(bus.rsp_data_o), exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      chk($sformatf("no_rsp@%0d", cyc), 32'(bus.rsp_valid_o), 32'd0);
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_ni  = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_addr_i   = {32'h0000_0300, 32'h0000_0204, 32'h0000_0100};
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;

    //  rv     gnt  rval rdata            mreq rdy     addr          busy rsp
    // round robin, all valid, one response per cycle from the 2nd accept
    add(3'b111, 1, 0, 32'h0,          1, 3'b001, 32'h100, 0, 3'b000);
    add(3'b111, 1, 1, 32'h0000_00A1,  1, 3'b010, 32'h204, 1, 3'b001);
    add(3'b111, 1, 1, 32'h0000_00A2,  1, 3'b100, 32'h300, 1, 3'b010);
    add(3'b111, 1, 1, 32'h0000_00A3,  1, 3'b001, 32'h100, 1, 3'b100);
    add(3'b111, 1, 1, 32'h0000_00A4,  1, 3'b010, 32'h204, 1, 3'b001);
    add(3'b111, 1, 1, 32'h0000_00A5,  1, 3'b100, 32'h300, 1, 3'b010);
    add(3'b000, 0, 1, 32'h0000_00A6,  0, 3'b000, 32'h0,   1, 3'b100);
    // rr_ptr must be back at 0: {2,0} valid grants 0, no accept
    add(3'b101, 0, 0, 32'h0,          1, 3'b000, 32'h100, 0, 3'b000);
    // single request, data two cycles after accept
    add(3'b001, 1, 0, 32'h0,          1, 3'b001, 32'h100, 0, 3'b000);
    add(3'b000, 0, 0, 32'h0,          0, 3'b000, 32'h0,   1, 3'b000);
    add(3'b000, 0, 1, 32'h0000_DEAD,  0, 3'b000, 32'h0,   1, 3'b001);
    add(3'b000, 0, 0, 32'h0,          0, 3'b000, 32'h0,   0, 3'b000);
    // stall: gnt low for 5 cycles, then accept
    for (int i = 0; i < 5; i++)
      add(3'b010, 0, 0, 32'h0,        1, 3'b000, 32'h204, 0, 3'b000);
    add(3'b010, 1, 0, 32'h0,          1, 3'b010, 32'h204, 0, 3'b000);
    add(3'b000, 0, 1, 32'h0000_0055,  0, 3'b000, 32'h0,   1, 3'b010);
    add(3'b000, 0, 0, 32'h0,          0, 3'b000, 32'h0,   0, 3'b000);
    // request dropped before acceptance is never granted
    add(3'b010, 0, 0, 32'h0,          1, 3'b000, 32'h204, 0, 3'b000);
    add(3'b000, 1, 0, 32'h0,          0, 3'b000, 32'h0,   0, 3'b000);
    // full: four accepts, blocked, pop does not reopen in the pop cycle
    add(3'b111, 1, 0, 32'h0,          1, 3'b100, 32'h300, 0, 3'b000);
    add(3'b111, 1, 0, 32'h0,          1, 3'b001, 32'h100, 1, 3'b000);
    add(3'b111, 1, 0, 32'h0,          1, 3'b010, 32'h204, 1, 3'b000);
    add(3'b111, 1, 0, 32'h0,          1, 3'b100, 32'h300, 1, 3'b000);
    add(3'b111, 1, 0, 32'h0,          0, 3'b000, 32'h0,   1, 3'b000);
    add(3'b111, 1, 1, 32'h0000_00B0,  0, 3'b000, 32'h0,   1, 3'b100);
    add(3'b111, 1, 0, 32'h0,          1, 3'b001, 32'h100, 1, 3'b000);
    add(3'b000, 0, 1, 32'h0000_00B1,  0, 3'b000, 32'h0,   1, 3'b001);
    add(3'b000, 0, 1, 32'h0000_00B2,  0, 3'b000, 32'h0,   1, 3'b010);
    add(3'b000, 0, 1, 32'h0000_00B3,  0, 3'b000, 32'h0,   1, 3'b100);
    add(3'b000, 0, 1, 32'h0000_00B4,  0, 3'b000, 32'h0,   1, 3'b001);
    add(3'b000, 0, 0, 32'h0,          0, 3'b000, 32'h0,   0, 3'b000);
    // interleaved 2,0,2 with push+pop in the same cycle
    add(3'b100, 1, 0, 32'h0,          1, 3'b100, 32'h300, 0, 3'b000);
    add(3'b001, 1, 1, 32'h0000_0011,  1, 3'b001, 32'h100, 1, 3'b100);
    add(3'b100, 1, 1, 32'h0000_0022,  1, 3'b100, 32'h300, 1, 3'b001);
    add(3'b000, 0, 1, 32'h0000_0033,  0, 3'b000, 32'h0,   1, 3'b100);
    add(3'b000, 0, 0, 32'h0,          0, 3'b000, 32'h0,   0, 3'b000);

    #3;
    chk("reset_busy",      32'(bus.busy_o),      32'd0);
    chk("reset_err",       32'(bus.err_o),       32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("reset_rsp_data",  bus.rsp_data_o,       32'd0);
    chk("reset_mem_req",   32'(bus.mem_req_o),   32'd0);
    chk("reset_ready",     32'(bus.req_ready_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      bus.req_valid_i  = vecs[i].rv;
      bus.mem_gnt_i    = vecs[i].gnt;
      bus.mem_rvalid_i = vecs[i].rval;
      bus.mem_rdata_i  = vecs[i].rdata;
      if (vecs[i].rval)
        exp_q.push_back('{due: cyc + 1, oh: vecs[i].exp_rsp, data: vecs[i].rdata});
      #1;
      chk($sformatf("v%0d_mem_req", i), 32'(bus.mem_req_o),   32'(vecs[i].exp_mreq));
      chk($sformatf("v%0d_ready", i),   32'(bus.req_ready_o), 32'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr_o,      vecs[i].exp_addr);
      chk($sformatf("v%0d_busy", i),    32'(bus.busy_o),      32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_err", i),     32'(bus.err_o),       32'd0);
      step();
    end

    // reset with two reads in flight, then a stale response arrives
    bus.mem_rvalid_i = 1'b0;
    bus.req_valid_i  = 3'b001;
    bus.mem_gnt_i    = 1'b1;
    #1;
    chk("mid_accept0", 32'(bus.req_ready_o), 32'b001);
    step();
    bus.req_valid_i = 3'b010;
    #1;
    chk("mid_accept1", 32'(bus.req_ready_o), 32'b010);
    step();
    bus.req_valid_i = 3'b000;
    bus.mem_gnt_i   = 1'b0;
    #1;
    chk("mid_busy_before", 32'(bus.busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_busy_in_reset", 32'(bus.busy_o),    32'd0);
    chk("mid_mem_req_reset", 32'(bus.mem_req_o), 32'd0);
    step();
    rst_ni = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0000_0077;
    #1;
    chk("mid_busy_after", 32'(bus.busy_o), 32'd0);
    step();
    bus.mem_rvalid_i = 1'b0;
    chk("spurious_err",       32'(bus.err_o),       32'd1);
    chk("spurious_busy",      32'(bus.busy_o),      32'd0);
    chk("spurious_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    repeat (3) step();
    chk("err_sticky", 32'(bus.err_o), 32'd1);

    repeat (2) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
